// File: rtl/spi_master_cfg_writer.sv
// SPI mode-0 master for configuration transactions: a 3-byte header (cmd, addr MSB, addr LSB)
// followed by up to 320 streamed payload bytes, with MISO captured for every payload byte.
module spi_master_cfg_writer #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [15:0] addr,
  input  logic [8:0]  len,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        done,
  output logic        SCLK,
  output logic        MOSI,
  output logic        SS,
  input  logic        MISO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [8:0]       MAX_LEN  = 9'd320;
  localparam logic [8:0]       HDR_LAST = 9'd2;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             sclk_q;
  logic [2:0]       bit_cnt;
  logic [8:0]       byte_idx;
  logic [8:0]       last_idx;
  logic [15:0]      addr_q;
  logic [7:0]       tx_shift;
  logic [7:0]       rx_shift;
  logic             rx_pend;

  logic tick, rise, fall, byte_end, last_byte;

  // tick marks the last clk cycle of an SCLK half-period (and of the HOLD wait).
  assign tick      = (div_cnt == DIV_LAST);
  assign rise      = (state == SHIFT) && tick && !sclk_q;
  assign fall      = (state == SHIFT) && tick && sclk_q;
  assign byte_end  = fall && (bit_cnt == 3'd7);
  assign last_byte = (byte_idx == last_idx);

  // NOTE: state is registered with non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    SS        = 1'b0;
    MOSI      = tx_shift[7];
    tx_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        SS   = 1'b1;
        MOSI = 1'b0;
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        // The byte following byte index 2 onward comes from the payload source.
        if (byte_end && !last_byte && (byte_idx >= HDR_LAST)) tx_ready = 1'b1;
        if (byte_end && last_byte) state_nxt = HOLD;
      end
      HOLD: begin
        if (tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign SCLK = sclk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      sclk_q   <= 1'b0;
      bit_cnt  <= 3'd0;
      byte_idx <= 9'd0;
      last_idx <= 9'd0;
      addr_q   <= 16'd0;
      tx_shift <= 8'd0;
      rx_shift <= 8'd0;
      rx_pend  <= 1'b0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      rx_pend  <= 1'b0;
      rx_valid <= rx_pend;
      done     <= (state == HOLD) && tick;
      if (rx_pend) rx_data <= rx_shift;

      unique case (state)
        IDLE: begin
          div_cnt  <= '0;
          sclk_q   <= 1'b0;
          bit_cnt  <= 3'd0;
          byte_idx <= 9'd0;
          if (start) begin
            tx_shift <= cmd;
            addr_q   <= addr;
            last_idx <= HDR_LAST + ((len > MAX_LEN) ? MAX_LEN : len);
          end
        end

        SHIFT: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) sclk_q <= ~sclk_q;

          if (rise) begin
            rx_shift <= {rx_shift[6:0], MISO};
            // Header bytes (indices 0..2) are shifted in but never reported.
            if ((bit_cnt == 3'd7) && (byte_idx > HDR_LAST)) rx_pend <= 1'b1;
          end

          if (fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              // On the final byte MOSI keeps bit 0 until SS rises.
              if (!last_byte) begin
                byte_idx <= byte_idx + 9'd1;
                if (byte_idx == 9'd0)      tx_shift <= addr_q[15:8];
                else if (byte_idx == 9'd1) tx_shift <= addr_q[7:0];
                else                       tx_shift <= tx_data;
              end
            end else begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
        end

        HOLD: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end

        default: div_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_cfg_writer.sv
// Self-checking bench: two DUTs (CLK_DIV=2 and CLK_DIV=1) behind a selector, a byte-level SPI
// slave model, and expectations computed from the transaction timing formulas.
module tb_spi_master_cfg_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, sel;
  logic [7:0]  cmd;
  logic [15:0] addr;
  logic [8:0]  len;
  logic [7:0]  tx_data;
  logic        MISO;

  logic       start_a, tx_ready_a, rx_valid_a, busy_a, done_a, sclk_a, mosi_a, ss_a;
  logic       start_b, tx_ready_b, rx_valid_b, busy_b, done_b, sclk_b, mosi_b, ss_b;
  logic [7:0] rx_data_a, rx_data_b;

  logic       tx_ready, rx_valid, busy, done, SCLK, MOSI, SS;
  logic [7:0] rx_data;

  assign start_a  = start & ~sel;
  assign start_b  = start & sel;
  assign tx_ready = sel ? tx_ready_b : tx_ready_a;
  assign rx_valid = sel ? rx_valid_b : rx_valid_a;
  assign rx_data  = sel ? rx_data_b  : rx_data_a;
  assign busy     = sel ? busy_b     : busy_a;
  assign done     = sel ? done_b     : done_a;
  assign SCLK     = sel ? sclk_b     : sclk_a;
  assign MOSI     = sel ? mosi_b     : mosi_a;
  assign SS       = sel ? ss_b       : ss_a;

  spi_master_cfg_writer #(.CLK_DIV(2)) dut_div2 (
    .clk(clk), .reset(reset), .start(start_a), .cmd(cmd), .addr(addr), .len(len),
    .tx_data(tx_data), .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .busy(busy_a), .done(done_a), .SCLK(sclk_a), .MOSI(mosi_a), .SS(ss_a), .MISO(MISO)
  );

  spi_master_cfg_writer #(.CLK_DIV(1)) dut_div1 (
    .clk(clk), .reset(reset), .start(start_b), .cmd(cmd), .addr(addr), .len(len),
    .tx_data(tx_data), .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .busy(busy_b), .done(done_b), .SCLK(sclk_b), .MOSI(mosi_b), .SS(ss_b), .MISO(MISO)
  );

  int n_pass   = 0;
  int n_checks = 0;

  logic [7:0] pay      [0:319];
  logic [7:0] miso_pay [0:319];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 320; i++) begin
      pay[i]      = 8'($urandom);
      miso_pay[i] = 8'($urandom);
    end
  endtask

  // Runs one transaction and checks it against the timing formulas. Returns in the done cycle.
  task automatic run_txn(input string name, input logic [7:0] t_cmd, input logic [15:0] t_addr,
                         input logic [8:0] t_len, input bit t_sel, input int mid_start);
    int cd, nl, nb, end_c, limit;
    logic [7:0] exp_bytes[$];
    logic [7:0] miso_bytes[$];
    logic [7:0] got_bytes[$];
    logic [7:0] sh;
    int nbits, rises, pay_idx;
    bit pop_pend, prev_sclk, exp_rdy;
    int ss_low, done_c, sclk_bad, busy_bad, rdy_bad, rdy_n, rxv_n, rxd_bad, byte_bad;
    logic mosi_end;

    cd    = t_sel ? 1 : 2;
    nl    = (t_len > 9'd320) ? 320 : int'(t_len);
    nb    = 3 + nl;
    end_c = 1 + (16 * nb + 1) * cd;
    limit = end_c + 4;

    exp_bytes.push_back(t_cmd);
    exp_bytes.push_back(t_addr[15:8]);
    exp_bytes.push_back(t_addr[7:0]);
    for (int j = 0; j < nl; j++) exp_bytes.push_back(pay[j]);
    for (int j = 0; j < 3; j++) miso_bytes.push_back(8'($urandom));
    for (int j = 0; j < nl; j++) miso_bytes.push_back(miso_pay[j]);

    sh = 8'd0; nbits = 0; rises = 0; pay_idx = 0; pop_pend = 0; prev_sclk = 0;
    ss_low = 0; done_c = -1; sclk_bad = 0; busy_bad = 0; rdy_bad = 0; rdy_n = 0;
    rxv_n = 0; rxd_bad = 0; byte_bad = 0; mosi_end = 1'b1;

    @(negedge clk);
    sel     = t_sel;
    cmd     = t_cmd;
    addr    = t_addr;
    len     = t_len;
    tx_data = pay[0];
    MISO    = miso_bytes[0][7];
    start   = 1'b1;

    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (mid_start != 0 && c == mid_start) begin
        start = 1'b1; cmd = ~t_cmd; addr = ~t_addr; len = 9'd7;
      end
      if (mid_start != 0 && c == mid_start + 1) start = 1'b0;

      // Show-ahead byte source: advance after each consumed byte.
      if (pop_pend) begin
        pay_idx++;
        tx_data = (pay_idx < nl) ? pay[pay_idx] : 8'($urandom);
      end
      pop_pend = (tx_ready === 1'b1);

      // Slave: capture MOSI on SCLK rise, present the next MISO bit afterwards.
      if (SS === 1'b0 && !prev_sclk && SCLK === 1'b1) begin
        sh = {sh[6:0], MOSI};
        nbits++;
        rises++;
        if (nbits % 8 == 0) got_bytes.push_back(sh);
        if (rises < 8 * nb) MISO = miso_bytes[rises / 8][7 - (rises % 8)];
      end
      prev_sclk = (SCLK === 1'b1);

      if (SCLK !== ((c <= 16 * nb * cd) && (((c - 1) / cd) % 2 == 1))) sclk_bad++;
      if (SS === 1'b0) ss_low++;
      if (busy !== (c < end_c)) busy_bad++;
      exp_rdy = (c % (16 * cd) == 0) && (c / (16 * cd) >= 3) && (c / (16 * cd) < nb);
      if (tx_ready !== exp_rdy) rdy_bad++;
      if (tx_ready === 1'b1) rdy_n++;
      if (rx_valid === 1'b1) begin
        if (rxv_n < nl && rx_data !== miso_bytes[3 + rxv_n]) rxd_bad++;
        rxv_n++;
      end
      if (done === 1'b1) begin
        done_c   = c;
        mosi_end = MOSI;
        break;
      end
    end

    for (int i = 0; i < got_bytes.size() && i < nb; i++)
      if (got_bytes[i] !== exp_bytes[i]) byte_bad++;

    check({name, "/done_cycle"}, done_c, end_c);
    check({name, "/ss_low_cycles"}, ss_low, (16 * nb + 1) * cd);
    check({name, "/sclk_wave_errs"}, sclk_bad, 0);
    check({name, "/busy_errs"}, busy_bad, 0);
    check({name, "/slave_byte_count"}, got_bytes.size(), nb);
    check({name, "/slave_byte_errs"}, byte_bad, 0);
    check({name, "/tx_ready_count"}, rdy_n, nl);
    check({name, "/tx_ready_timing_errs"}, rdy_bad, 0);
    check({name, "/rx_valid_count"}, rxv_n, nl);
    check({name, "/rx_data_errs"}, rxd_bad, 0);
    check({name, "/mosi_after_ss"}, mosi_end, 1'b0);
  endtask

  task automatic run_abort();
    int done_n, ss_low;
    done_n = 0;
    ss_low = 0;
    @(negedge clk);
    sel = 1'b0; cmd = 8'h9C; addr = 16'h4242; len = 9'd2; tx_data = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (69) @(negedge clk);   // cycle t0+70: inside byte index 2
    check("abort/ss_before_reset", SS, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("abort/outs_after_reset", {SS, SCLK, MOSI, busy, done}, 5'b10000);
    reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_n++;
      if (SS !== 1'b1) ss_low++;
    end
    check("abort/done_pulses", done_n, 0);
    check("abort/ss_low_after", ss_low, 0);
  endtask

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0; sel = 1'b0; cmd = 8'd0; addr = 16'd0; len = 9'd0;
    tx_data = 8'd0; MISO = 1'b0;

    repeat (3) @(negedge clk);
    check("reset/outs_div2", {ss_a, sclk_a, mosi_a, busy_a, done_a, tx_ready_a, rx_valid_a, rx_data_a},
          {1'b1, 14'd0});
    check("reset/outs_div1", {ss_b, sclk_b, mosi_b, busy_b, done_b, tx_ready_b, rx_valid_b, rx_data_b},
          {1'b1, 14'd0});
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ({ss_a, sclk_a, mosi_a, busy_a} !== 4'b1000) bad++;
      if ({ss_b, sclk_b, mosi_b, busy_b} !== 4'b1000) bad++;
    end
    check("reset/idle_errs", bad, 0);

    fill_random();
    run_txn("hdr", 8'h01, 16'h0123, 9'd0, 1'b0, 0);
    repeat (3) @(negedge clk);

    fill_random();
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'hFF; pay[3] = 8'h00;
    run_txn("write", 8'h02, 16'h1F40, 9'd4, 1'b0, 0);
    repeat (3) @(negedge clk);

    fill_random();
    miso_pay[0] = 8'h5A; miso_pay[1] = 8'h81;
    run_txn("read", 8'h0B, 16'h0040, 9'd2, 1'b0, 0);
    repeat (2) @(negedge clk);

    fill_random();
    run_txn("busy_start", 8'h02, 16'hBEEF, 9'd3, 1'b0, 40);
    fill_random();
    run_txn("back2back", 8'h03, 16'h00C5, 9'd1, 1'b0, 0);
    repeat (3) @(negedge clk);

    run_abort();
    repeat (3) @(negedge clk);

    fill_random();
    run_txn("len400", 8'h02, 16'h2000, 9'd400, 1'b0, 0);
    repeat (3) @(negedge clk);

    fill_random();
    run_txn("div1", 8'hC3, 16'h7E81, 9'd5, 1'b1, 0);
    fill_random();
    run_txn("div1_hdr", 8'h3C, 16'h8001, 9'd0, 1'b1, 0);
    repeat (2) @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_txn($sformatf("rand%0d", t), 8'($urandom), 16'($urandom),
              9'($urandom_range(0, 12)), 1'($urandom), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
